battle_hp_datapath: RTL and testbench

//  Responder to the battle control FSM. Owns the player and AI Pokemon HP registers.

---
 rtl/battle_hp_datapath.sv | 114 +++++++++++
 tb/tb_battle_hp_datapath.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/battle_hp_datapath.sv
// Battle HP datapath: owns player/AI HP, loads AI HP, and drains damage one
// point per DRAIN_DIV cycles so the health bar can animate. Reports done,
// fainted and malformed-command status back to the battle control FSM.
module battle_hp_datapath #(
  parameter int HP_W      = 8,
  parameter int P_MAX_HP  = 100,
  parameter int AI_MAX_HP = 100,
  parameter int P_ATK     = 20,
  parameter int AI_ATK    = 15,
  parameter int DRAIN_DIV = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_ai_hp,
  input  logic            apply_p_damage,
  input  logic            apply_ai_damage,
  input  logic            active_trainer,
  input  logic            target,
  input  logic [HP_W-1:0] ai_hp_init,
  output logic [HP_W-1:0] p_hp,
  output logic [HP_W-1:0] ai_hp,
  output logic            p_fainted,
  output logic            ai_fainted,
  output logic            busy,
  output logic            done,
  output logic            cmd_err
);

  localparam int TW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DRAIN_DIV - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t          state;
  logic [HP_W-1:0] rem;
  logic [TW-1:0]   tick;
  logic            tgt_ai;

  logic [HP_W-1:0] amt, tgt_hp, first_rem, init_clamp;
  logic            any_apply, bad_cmd;

  // Decode the command presented in IDLE: damage amount, saturated drain
  // length, clamped AI load value and malformed-command detection.
  always_comb begin
    amt        = active_trainer ? HP_W'(AI_ATK) : HP_W'(P_ATK);
    tgt_hp     = apply_ai_damage ? ai_hp : p_hp;
    first_rem  = (amt < tgt_hp) ? amt : tgt_hp;
    init_clamp = (ai_hp_init > HP_W'(AI_MAX_HP)) ? HP_W'(AI_MAX_HP) : ai_hp_init;
    any_apply  = apply_p_damage | apply_ai_damage;
    bad_cmd    = (apply_p_damage & apply_ai_damage) |
                 (any_apply & load_ai_hp) |
                 (apply_p_damage & target) |
                 (apply_ai_damage & ~target);
  end

  // Control FSM plus HP registers; done/cmd_err are registered one-cycle pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      p_hp    <= HP_W'(P_MAX_HP);
      ai_hp   <= HP_W'(AI_MAX_HP);
      rem     <= '0;
      tick    <= '0;
      tgt_ai  <= 1'b0;
      done    <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      done    <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bad_cmd) begin
            cmd_err <= 1'b1;
          end else if (load_ai_hp) begin
            ai_hp <= init_clamp;
            state <= DONE;
            done  <= 1'b1;
          end else if (any_apply) begin
            rem    <= first_rem;
            tgt_ai <= apply_ai_damage;
            tick   <= '0;
            if (first_rem == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (tick == TICK_LAST) begin
            tick <= '0;
            rem  <= rem - 1'b1;
            if (tgt_ai) ai_hp <= ai_hp - 1'b1;
            else        p_hp  <= p_hp - 1'b1;
            if (rem == HP_W'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign p_fainted  = (p_hp == '0);
  assign ai_fainted = (ai_hp == '0);

endmodule

// File: tb/tb_battle_hp_datapath.sv
// Scoreboard bench: two DUTs (DRAIN_DIV=1 and 4) share one command stream.
// The driver computes expected HP, response kind, arrival cycle and busy
// length from the battle rules; per-DUT monitors pop and compare on done/cmd_err.
module tb_battle_hp_datapath;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load_ai_hp, apply_p_damage, apply_ai_damage, active_trainer, target;
  logic [7:0] ai_hp_init;

  logic [7:0] p1, a1, p4, a4;
  logic       pf1, af1, b1, d1, e1, pf4, af4, b4, d4, e4;

  always #5 clk = ~clk;

  battle_hp_datapath #(.DRAIN_DIV(1)) u_d1 (
    .clk(clk), .reset_n(reset_n), .load_ai_hp(load_ai_hp),
    .apply_p_damage(apply_p_damage), .apply_ai_damage(apply_ai_damage),
    .active_trainer(active_trainer), .target(target), .ai_hp_init(ai_hp_init),
    .p_hp(p1), .ai_hp(a1), .p_fainted(pf1), .ai_fainted(af1),
    .busy(b1), .done(d1), .cmd_err(e1));

  battle_hp_datapath #(.DRAIN_DIV(4)) u_d4 (
    .clk(clk), .reset_n(reset_n), .load_ai_hp(load_ai_hp),
    .apply_p_damage(apply_p_damage), .apply_ai_damage(apply_ai_damage),
    .active_trainer(active_trainer), .target(target), .ai_hp_init(ai_hp_init),
    .p_hp(p4), .ai_hp(a4), .p_fainted(pf4), .ai_fainted(af4),
    .busy(b4), .done(d4), .cmd_err(e4));

  typedef struct { bit err; int p; int ai; int cyc; int bcnt; } exp_t;
  exp_t q1[$], q4[$];
  exp_t x1, x4;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int bc1 = 0, bc4 = 0;
  int m_p = 100, m_ai = 100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // DIV=1 monitor
  always @(negedge clk) begin
    if (b1) bc1++;
    if (d1 || e1) begin
      if (q1.size() == 0) chk("d1 unexpected response", 1, 0);
      else begin
        x1 = q1.pop_front();
        chk("d1 cmd_err kind", 32'(e1), 32'(x1.err));
        chk("d1 done kind", 32'(d1), 32'(!x1.err));
        chk("d1 p_hp", 32'(p1), x1.p);
        chk("d1 ai_hp", 32'(a1), x1.ai);
        chk("d1 latency cycle", cyc, x1.cyc);
        chk("d1 busy cycles", bc1, x1.bcnt);
      end
      bc1 = 0;
    end
  end

  // DIV=4 monitor
  always @(negedge clk) begin
    if (b4) bc4++;
    if (d4 || e4) begin
      if (q4.size() == 0) chk("d4 unexpected response", 1, 0);
      else begin
        x4 = q4.pop_front();
        chk("d4 cmd_err kind", 32'(e4), 32'(x4.err));
        chk("d4 done kind", 32'(d4), 32'(!x4.err));
        chk("d4 p_hp", 32'(p4), x4.p);
        chk("d4 ai_hp", 32'(a4), x4.ai);
        chk("d4 latency cycle", cyc, x4.cyc);
        chk("d4 busy cycles", bc4, x4.bcnt);
      end
      bc4 = 0;
    end
  end

  task automatic clear_in();
    load_ai_hp = 0; apply_p_damage = 0; apply_ai_damage = 0;
    active_trainer = 0; target = 0; ai_hp_init = 0;
  endtask

  // Issue one command for one cycle, predict the outcome, optionally inject
  // ignored strobes during the drain. Does not wait for completion.
  task automatic issue(input bit ld, input bit ap, input bit aa, input bit tr,
                       input bit tg, input int init);
    exp_t e;
    bit bad;
    int n = 0, amt;
    bad = (ap && aa) || ((ap || aa) && ld) || (ap && tg) || (aa && !tg);
    if (!bad) begin
      if (ld) m_ai = (init > 100) ? 100 : init;
      else begin
        amt = tr ? 15 : 20;
        if (aa) begin n = (amt < m_ai) ? amt : m_ai; m_ai -= n; end
        else    begin n = (amt < m_p)  ? amt : m_p;  m_p  -= n; end
      end
    end
    @(negedge clk);
    load_ai_hp = ld; apply_p_damage = ap; apply_ai_damage = aa;
    active_trainer = tr; target = tg; ai_hp_init = 8'(init);
    e.err = bad; e.p = m_p; e.ai = m_ai;
    e.cyc = cyc + 1 + n;     e.bcnt = bad ? 0 : n + 1;     q1.push_back(e);
    e.cyc = cyc + 1 + n * 4; e.bcnt = bad ? 0 : n * 4 + 1; q4.push_back(e);
    @(negedge clk);
    if (!bad && n >= 2) begin
      load_ai_hp = 1'($urandom); apply_p_damage = 1'($urandom);
      apply_ai_damage = 1'($urandom); active_trainer = 1'($urandom);
      target = 1'($urandom); ai_hp_init = 8'($urandom);
      @(negedge clk);
    end
    clear_in();
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((b1 || b4) && k < 300) begin @(negedge clk); k++; end
    if (k >= 300) chk("wait idle timeout", 1, 0);
    @(negedge clk);
    chk("d1 idle p_hp", 32'(p1), m_p);
    chk("d1 idle ai_hp", 32'(a1), m_ai);
    chk("d4 idle p_hp", 32'(p4), m_p);
    chk("d4 idle ai_hp", 32'(a4), m_ai);
    chk("d1 p_fainted", 32'(pf1), 32'(m_p == 0));
    chk("d1 ai_fainted", 32'(af1), 32'(m_ai == 0));
    chk("d4 p_fainted", 32'(pf4), 32'(m_p == 0));
    chk("d4 ai_fainted", 32'(af4), 32'(m_ai == 0));
  endtask

  task automatic op(input bit ld, input bit ap, input bit aa, input bit tr,
                    input bit tg, input int init);
    issue(ld, ap, aa, tr, tg, init);
    wait_idle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, ai_v, bsel;
    clear_in();
    reset_n = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    chk("reset p_hp", 32'(p1), 100);
    chk("reset ai_hp", 32'(a4), 100);
    chk("reset busy", 32'({b1, b4}), 0);
    chk("reset done/err", 32'({d1, e1, d4, e4}), 0);
    chk("reset fainted", 32'({pf1, af1, pf4, af4}), 0);

    op(0, 0, 1, 0, 1, 0);        // player hits AI: 100 -> 80
    op(1, 0, 0, 0, 0, 10);       // AI at 10
    op(0, 0, 1, 0, 1, 0);        // 20 damage saturates at 0
    op(1, 0, 0, 0, 0, 150);      // clamp to 100
    op(0, 1, 1, 0, 0, 0);        // both strobes
    op(0, 1, 0, 0, 1, 0);        // target mismatch
    op(1, 0, 1, 0, 1, 5);        // load with apply
    for (int i = 0; i < 5; i++) op(0, 1, 0, 0, 0, 0);   // player to 0
    op(0, 1, 0, 1, 0, 0);        // rem=0 path

    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      if (k < 2) begin
        ai_v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : $urandom_range(0, 255);
        op(1, 0, 0, 1'($urandom), 1'($urandom), ai_v);
      end else if (k < 8) begin
        bsel = $urandom_range(0, 1);
        op(0, !bsel[0], bsel[0], 1'($urandom), bsel[0], 0);
      end else begin
        case ($urandom_range(0, 3))
          0: op(0, 1, 1, 1'($urandom), 1'($urandom), 0);
          1: op(1, 1'($urandom), 1, 1'($urandom), 1'($urandom), 50);
          2: op(0, 1, 0, 1'($urandom), 1, 0);
          default: op(0, 0, 1, 1'($urandom), 0, 0);
        endcase
      end
    end

    // Reset in the middle of a drain: partial damage discarded, no done.
    op(1, 0, 0, 0, 0, 100);
    issue(0, 0, 1, 0, 1, 0);
    repeat (5) @(negedge clk);
    reset_n = 0;
    q1.delete(); q4.delete();
    m_p = 100; m_ai = 100;
    @(negedge clk);
    #1;
    reset_n = 1;
    bc1 = 0; bc4 = 0;
    chk("midreset busy", 32'({b1, b4}), 0);
    chk("midreset d1 p_hp", 32'(p1), 100);
    chk("midreset d1 ai_hp", 32'(a1), 100);
    chk("midreset d4 ai_hp", 32'(a4), 100);
    repeat (100) @(negedge clk);
    chk("midreset still idle", 32'({b1, b4}), 0);

    op(0, 0, 1, 1, 1, 0);        // AI self-target, 15 damage
    repeat (5) @(negedge clk);
    chk("d1 queue drained", q1.size(), 0);
    chk("d4 queue drained", q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
